// File: rtl/text_access_sched.sv
// Text-area access scheduler: round-robin arbitration of two
// requesters onto the text_area8x8 host port, gated by blanking.
module text_access_sched #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                i_blank,
  input  logic [1:0]          i_req_valid,
  input  logic [1:0]          i_req_wr,
  input  logic [2*ADDR_W-1:0] i_req_addr,
  input  logic [15:0]         i_req_data,
  output logic [1:0]          o_req_ready,
  output logic [1:0]          o_rsp_valid,
  output logic [7:0]          o_rsp_data,
  input  logic [1:0]          i_rsp_ready,
  output logic                o_ta_rd,
  output logic                o_ta_wr,
  output logic [ADDR_W-1:0]   o_ta_addr,
  output logic [7:0]          o_ta_data,
  input  logic [7:0]          i_ta_data,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, RD_WAIT, RESP
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                own_q, own_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          rsp_q, rsp_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                sel;
  logic                take;
  logic                strobe;

  // Grant selection: prefer the requester that did not win last time
  always_comb begin
    sel  = i_req_valid[~last_q] ? ~last_q : last_q;
    take = rstn_i && (state_q == IDLE) && i_blank
           && i_req_valid[sel];
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          last_d  = sel;
          own_d   = sel;
          wr_d    = i_req_wr[sel];
          addr_d  = sel ? i_req_addr[2*ADDR_W-1:ADDR_W]
                        : i_req_addr[ADDR_W-1:0];
          data_d  = sel ? i_req_data[15:8]
                        : i_req_data[7:0];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (i_blank) begin
          strobe = 1'b1;
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = 3'(RD_LAT);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_d   = i_ta_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready[own_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational port outputs derived from registered state
  always_comb begin
    o_req_ready = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
    o_rsp_valid = (state_q == RESP)
                  ? (own_q ? 2'b10 : 2'b01) : 2'b00;
    o_rsp_data  = rsp_q;
    o_ta_wr     = strobe & wr_q;
    o_ta_rd     = strobe & ~wr_q;
    o_ta_addr   = addr_q;
    o_ta_data   = data_q;
    o_busy      = (state_q != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_text_access_sched.sv
// Directed bench for text_access_sched: RD_LAT=1 and RD_LAT=3
// instances, hand-computed expectations.
module tb_text_access_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        blank = 1'b0;
  logic [1:0]  rq_v = '0, rq_w = '0, rs_r = '0;
  logic [15:0] rq_a = '0, rq_d = '0;
  logic [7:0]  ta_di = '0;
  logic [1:0]  rdy, rsp_v;
  logic [7:0]  rsp_d, ta_a, ta_do;
  logic        ta_rd, ta_wr, busy;

  logic        b_blank = 1'b0;
  logic [1:0]  b_v = '0, b_w = '0, b_rr = '0;
  logic [15:0] b_a = '0, b_d = '0;
  logic [7:0]  b_tdi = '0;
  logic [1:0]  b_rdy, b_rv;
  logic [7:0]  b_rd, b_ta, b_tdo;
  logic        b_trd, b_twr, b_busy;

  logic        bad;

  always #5 clk = ~clk;

  text_access_sched #(.ADDR_W(8), .RD_LAT(1)) u1 (
    .clk_i(clk), .rstn_i(rstn), .i_blank(blank),
    .i_req_valid(rq_v), .i_req_wr(rq_w),
    .i_req_addr(rq_a), .i_req_data(rq_d),
    .o_req_ready(rdy), .o_rsp_valid(rsp_v),
    .o_rsp_data(rsp_d), .i_rsp_ready(rs_r),
    .o_ta_rd(ta_rd), .o_ta_wr(ta_wr),
    .o_ta_addr(ta_a), .o_ta_data(ta_do),
    .i_ta_data(ta_di), .o_busy(busy)
  );

  text_access_sched #(.ADDR_W(8), .RD_LAT(3)) u3 (
    .clk_i(clk), .rstn_i(rstn), .i_blank(b_blank),
    .i_req_valid(b_v), .i_req_wr(b_w),
    .i_req_addr(b_a), .i_req_data(b_d),
    .o_req_ready(b_rdy), .o_rsp_valid(b_rv),
    .o_rsp_data(b_rd), .i_rsp_ready(b_rr),
    .o_ta_rd(b_trd), .o_ta_wr(b_twr),
    .o_ta_addr(b_ta), .o_ta_data(b_tdo),
    .i_ta_data(b_tdi), .o_busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_out", {rdy, rsp_v, rsp_d, ta_rd, ta_wr,
                    ta_a, ta_do, busy}, 32'd0);
    tick();
    tick();
    rstn = 1'b1;

    // write from requester 0
    blank = 1'b1;
    rq_v = 2'b01; rq_w = 2'b01;
    rq_a = 16'h0026; rq_d = 16'h0062;
    #1 chk("wr_ready", rdy, 2'b01);
    tick();
    rq_v = 2'b00;
    #1;
    chk("wr_strobe", {ta_wr, ta_rd, busy}, 3'b101);
    chk("wr_addr", ta_a, 8'h26);
    chk("wr_data", ta_do, 8'h62);
    chk("wr_no_rdy", rdy, 2'b00);
    tick();
    chk("wr_end", {ta_wr, busy}, 2'b00);

    // read from requester 1, RD_LAT=1
    rq_v = 2'b10; rq_w = 2'b00; rq_a = 16'h1000;
    #1 chk("rd_ready", rdy, 2'b10);
    tick();
    rq_v = 2'b00;
    #1;
    chk("rd_strobe", {ta_rd, ta_wr}, 2'b10);
    chk("rd_addr", ta_a, 8'h10);
    tick();
    ta_di = 8'hA5;
    #1 chk("rd_wait", {busy, rsp_v}, 3'b100);
    tick();
    ta_di = 8'h00;
    #1;
    chk("rsp_valid", rsp_v, 2'b10);
    chk("rsp_data", rsp_d, 8'hA5);
    rs_r = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_v !== 2'b10 || rsp_d !== 8'hA5) bad = 1'b1;
    end
    chk("rsp_hold", bad, 1'b0);
    rs_r = 2'b10;
    tick();
    rs_r = 2'b00;
    chk("rsp_done", {rsp_v, busy}, 3'b000);

    // round robin after a fresh reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rq_v = 2'b11; rq_w = 2'b11;
    rq_a = 16'h0201; rq_d = 16'hBBAA;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_grant", rdy, (i % 2) ? 2'b10 : 2'b01);
      tick();
      chk("rr_strobe", {ta_wr, rdy}, 3'b100);
      chk("rr_addr", ta_a, (i % 2) ? 8'h02 : 8'h01);
      tick();
    end
    rq_v = 2'b00;
    tick();

    // blanking holds off acceptance
    blank = 1'b0;
    rq_v = 2'b01; rq_w = 2'b01;
    rq_a = 16'h0033; rq_d = 16'h0044;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rdy !== 2'b00 || ta_wr || ta_rd) bad = 1'b1;
    end
    chk("blank_idle", bad, 1'b0);
    blank = 1'b1;
    #1 chk("blank_acc", rdy, 2'b01);
    tick();
    blank = 1'b0;
    rq_v = 2'b00;
    #1 chk("blank_nostb", ta_wr, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ta_wr || ta_rd || !busy) bad = 1'b1;
    end
    chk("blank_hold", bad, 1'b0);
    blank = 1'b1;
    #1;
    chk("blank_stb", {ta_wr, ta_a}, {1'b1, 8'h33});
    tick();
    chk("blank_end", {ta_wr, busy}, 2'b00);

    // async reset during RD_WAIT
    rq_v = 2'b01; rq_w = 2'b00; rq_a = 16'h0005;
    tick();
    rq_v = 2'b00;
    tick();
    chk("rw_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rw_rst", {ta_rd, rsp_v, busy}, 4'b0000);
    tick();
    rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_v !== 2'b00 || busy) bad = 1'b1;
    end
    chk("rw_no_rsp", bad, 1'b0);

    // RD_LAT=3 instance
    b_blank = 1'b1;
    b_v = 2'b01; b_w = 2'b00; b_a = 16'h0077;
    #1 chk("l3_ready", b_rdy, 2'b01);
    tick();
    b_v = 2'b00;
    chk("l3_strobe", {b_trd, b_ta}, {1'b1, 8'h77});
    tick();
    chk("l3_w1", {b_busy, b_rv, b_trd}, 4'b1000);
    tick();
    chk("l3_w2", {b_busy, b_rv}, 3'b100);
    tick();
    b_tdi = 8'h3C;
    #1 chk("l3_w3", {b_busy, b_rv}, 3'b100);
    tick();
    b_tdi = 8'h00;
    #1;
    chk("l3_rsp", b_rv, 2'b01);
    chk("l3_data", b_rd, 8'h3C);
    b_rr = 2'b01;
    tick();
    chk("l3_done", {b_rv, b_busy}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_access_sched.md
Name: text_access_sched

Overview:
- Arbitrates and schedules register accesses to the text_area8x8 host port (rd/wr/addr/data) between two requesters: port 0 = CPU, port 1 = host/debug.
- Replaces the ad-hoc vsync-driven test sequencer in the top level.
- Issues text-area strobes only while the display is blanked, one access at a time, with round-robin fairness.
- Returns read data to the originating requester over a valid/ready response channel.

Parameters:
- ADDR_W, 8: width of the text-area address.
- RD_LAT, 1: pix-clock cycles from the o_ta_rd strobe to valid i_ta_data (range 1..7).

Ports:
- clk_i  in  1  pixel clock; all logic posedge.
- rstn_i  in  1  asynchronous active-low reset.
- i_blank  in  1  1 = display blanked; text-area access permitted.
- i_req_valid  in  2  per-requester command valid.
- i_req_wr  in  2  per-requester: 1 = write, 0 = read.
- i_req_addr  in  2*ADDR_W  per-requester address; requester n uses [n*ADDR_W +: ADDR_W].
- i_req_data  in  16  per-requester write data; requester n uses [n*8 +: 8].
- o_req_ready  out  2  per-requester command accept.
- o_rsp_valid  out  2  per-requester read-response valid.
- o_rsp_data  out  8  read data, shared by both requesters; qualified by o_rsp_valid.
- i_rsp_ready  in  2  per-requester response accept.
- o_ta_rd  out  1  text-area read strobe.
- o_ta_wr  out  1  text-area write strobe.
- o_ta_addr  out  ADDR_W  text-area address.
- o_ta_data  out  8  text-area write data.
- i_ta_data  in  8  text-area read data.
- o_busy  out  1  1 = state is not IDLE.

Behaviour:
- Reset (async, rstn_i=0):
  - All outputs 0; state = IDLE; latency counter = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Strobes drop immediately, even mid-access. Any in-flight command or response is discarded and never reported.
- States: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE:
  - Acceptance requires i_blank=1 and at least one i_req_valid.
  - Selection: the requester other than `last` if it is valid, else `last`.
  - o_req_ready[sel] is driven combinationally (IDLE & i_blank & valid[sel]). o_req_ready is never 1 for both requesters, and never outside IDLE.
  - On accept: latch wr, addr, data and owner; set last = sel; go to ACCESS.
  - With i_blank=0 nothing is accepted; requests stay pending.
- ACCESS:
  - o_ta_addr and o_ta_data hold the latched values from accept until the next accept.
  - If i_blank=1: assert o_ta_wr (write) or o_ta_rd (read) for exactly this one cycle.
    - Write: go to IDLE.
    - Read: load counter = RD_LAT and go to RD_WAIT.
  - If i_blank=0: strobes stay low and the block holds in ACCESS until i_blank returns. The access is never dropped.
- RD_WAIT:
  - Counter decrements each cycle. When it reaches 0, capture i_ta_data into the response register and go to RESP.
  - i_blank is ignored here, because the strobe was already issued.
- RESP:
  - o_rsp_valid[owner]=1, o_rsp_data = captured value; both held stable until i_rsp_ready[owner]=1.
  - On handshake: o_rsp_valid goes 0 and the block goes to IDLE.
  - i_rsp_ready of the non-owner is ignored.
  - The next command may be accepted in the cycle after RESP exits, not in the same cycle.
- Latency, command accepted at edge T with i_blank held 1:
  - Write strobe at T+1; the next accept is possible at T+2.
  - Read strobe at T+1; data captured at the end of cycle T+1+RD_LAT; o_rsp_valid rises at T+2+RD_LAT.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Requester obligation: i_req_* must hold stable while valid is high and ready is low (standard valid/ready). The block does not check this.
- o_busy = (state != IDLE), registered-state based with no combinational path from inputs.

Test Plan:
- Reset release, i_blank=1, req0 write addr=0x26 data=0x62 → o_req_ready[0] in the same cycle; o_ta_wr=1 for exactly 1 cycle at T+1 with o_ta_addr=0x26, o_ta_data=0x62; o_busy returns 0 at T+2.
- Read, RD_LAT=1: req1 read addr=0x10, i_ta_data=0xA5 one cycle after o_ta_rd → o_rsp_valid[1]=1 at T+3 with o_rsp_data=0xA5; hold i_rsp_ready[1]=0 for 5 cycles → valid and data stable; ready=1 → valid clears next cycle.
- Both requesters valid with writes continuously, i_blank=1 → grant order 0,1,0,1 over 4 accesses; first grant after reset goes to requester 0.
- i_blank=0 with req0 valid → o_req_ready stays 0 for 100 cycles, no strobes. Accept during blank, then drop i_blank in the ACCESS cycle → no strobe until i_blank=1 again, then exactly one strobe.
- Assert rstn_i=0 during RD_WAIT → o_ta_rd, o_rsp_valid and o_busy read 0 before the next clock edge; after release no response appears.
- RD_LAT=3 build: read strobe at T+1, capture at T+4, o_rsp_valid at T+5.
